access_ctrl: RTL and testbench
==============================

Name: access_ctrl

Overview:
- Password access controller: an 8-bit password is latched on a rising edge of `enter` and searched sequentially against a fixed table of valid passwords.
- `resultado` reports grant (1) or deny (0).
- Sits between keypad/input logic and a door/lock actuator.
- The password table is a small read-only memory inside the block.

Parameters:
- DATA_W, 8, password width in bits.
- DEPTH, 16, number of stored passwords (table entries).
- IDX_W, 4, index width (clog2(DEPTH)).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, synchronous, active-low.
- enter  input  1  request strobe; a 0->1 transition starts a check.
- senha_digitada  input  DATA_W  typed password, sampled on the enter rising edge.
- resultado  output  1  1 = last checked password valid, 0 = invalid, idle or searching.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- rst==0 at an edge forces: state=IDLE, idx=0, pwd_q=0, enter_d=0, resultado=0. This overrides every other event, including an in-progress search.
- Edge detect: enter_d<=enter every cycle; start = enter & ~enter_d & (state==IDLE).
  - Holding enter high gives exactly one start.
  - enter rising outside IDLE is ignored, and still updates enter_d.
- FSM states: IDLE, SEARCH.
- IDLE:
  - On start at edge E: pwd_q<=senha_digitada, idx<=0, resultado<=0, state<=SEARCH.
  - Otherwise resultado holds its last value.
- SEARCH, each cycle compares table[idx] with pwd_q (combinational ROM read):
  - match: resultado<=1, state<=IDLE.
  - no match, idx==DEPTH-1: resultado<=0, state<=IDLE.
  - no match otherwise: idx<=idx+1.
- Latency:
  - Match at table index i: resultado=1 after edge E+1+i.
  - Miss: resultado stays 0; block returns to IDLE after edge E+DEPTH.
  - A new start is accepted from the first IDLE cycle.
- The result holds until the next accepted start, which clears it to 0 immediately.
- Comparison is an exact equality on all DATA_W bits.
- The table is constant. The first match terminates the search, so duplicate entries are harmless.
- Table contents, index 0..15: 146, 199, 23, 57, 88, 101, 120, 133, 160, 175, 190, 210, 222, 240, 250, 7.
- Value 1 is deliberately absent.
- senha_digitada changes outside the sampling edge have no effect.

Decomposition:
- Package access_ctrl_pkg holds:
  - DATA_W, DEPTH and IDX_W constants;
  - the FSM state enum (IDLE, SEARCH);
  - the constant password table array.
- Sub-module pwd_rom: address in (IDX_W), data out (DATA_W), combinational lookup of the package table.
- Top access_ctrl holds the edge detector, password latch, index counter, FSM and the resultado register.

Test Plan:
- Reset: hold rst=0 for 5 cycles with enter toggling -> resultado=0, no search starts; release rst=1 -> stays 0.
- Valid at index 0: senha=146, pulse enter for 1 cycle at edge E -> resultado=1 after E+1, held until the next start.
- Invalid: senha=1, enter pulse at E -> resultado drops to 0 after E, stays 0; back in IDLE after E+16.
- Valid at index 1: senha=199, enter pulse -> resultado=1 after E+2.
  - Also senha=7 (last entry) -> resultado=1 after E+16.
- enter held high 10 cycles with senha=146, and a second enter edge during a search for 1 -> exactly one search each; the second edge is ignored and the result is 0.
- Reset mid-search: start senha=7, drive rst=0 at E+5 -> resultado=0, IDLE; the next enter with 146 grants normally.

Source files
------------

// File: rtl/access_ctrl_pkg.sv
// rtl/access_ctrl_pkg.sv - shared constants, FSM states and password table for access_ctrl
package access_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  // Fixed list of accepted passwords; value 1 is intentionally not present.
  localparam logic [DATA_W-1:0] PWD_TABLE [DEPTH] = '{
    8'd146, 8'd199, 8'd23,  8'd57,
    8'd88,  8'd101, 8'd120, 8'd133,
    8'd160, 8'd175, 8'd190, 8'd210,
    8'd222, 8'd240, 8'd250, 8'd7
  };

endpackage

// File: rtl/access_ctrl_pwd_rom.sv
// rtl/access_ctrl_pwd_rom.sv - combinational lookup of the fixed password table
module pwd_rom
  import access_ctrl_pkg::*;
(
  input  logic [IDX_W-1:0]  addr,
  output logic [DATA_W-1:0] data
);

  // Pure table read; every address maps to a defined entry.
  always_comb begin
    data = PWD_TABLE[addr];
  end

endmodule

// File: rtl/access_ctrl.sv
// rtl/access_ctrl.sv - latches a typed password and scans the table for a match
module access_ctrl
  import access_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enter,
  input  logic [DATA_W-1:0] senha_digitada,
  output logic              resultado
);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   pwd_q;
  logic                enter_d;
  logic [DATA_W-1:0]   rom_data;
  logic                start;
  logic                hit;
  logic                last_entry;

  pwd_rom u_rom (
    .addr (idx),
    .data (rom_data)
  );

  // A request is a fresh 0->1 on enter seen while no search is running.
  always_comb begin
    start      = enter & ~enter_d & (state == IDLE);
    hit        = (rom_data == pwd_q);
    last_entry = (idx == IDX_W'(DEPTH - 1));
  end

  // Edge detector, password latch, index walk and registered grant/deny.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      pwd_q     <= '0;
      enter_d   <= 1'b0;
      resultado <= 1'b0;
    end else begin
      enter_d <= enter;
      case (state)
        IDLE: begin
          if (start) begin
            pwd_q     <= senha_digitada;
            idx       <= '0;
            resultado <= 1'b0;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            resultado <= 1'b1;
            state     <= IDLE;
          end else if (last_entry) begin
            resultado <= 1'b0;
            state     <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_access_ctrl.sv
// tb/tb_access_ctrl.sv - vector table plus corner sequences checked through a scoreboard queue
module tb_access_ctrl;

  logic       clk;
  logic       rst;
  logic       enter;
  logic [7:0] senha_digitada;
  logic       resultado;

  access_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .enter          (enter),
    .senha_digitada (senha_digitada),
    .resultado      (resultado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    k;
    bit    exp;
  } sb_t;

  typedef struct {
    logic [7:0] senha;
    bit         grant;
    int         lat;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_err = 0;

  // Scoreboard: one expected resultado value per cycle, checked away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      n_cmp++;
      if (resultado !== e.exp) begin
        n_err++;
        $display("FAIL %s k=%0d: resultado=%0b expected %0b", e.tag, e.k, resultado, e.exp);
      end
    end
  end

  // Expected trace after start edge E: cleared at E, granted from E+lat when matched.
  function automatic void push_seq(input string tag, input bit grant, input int lat, input int n);
    for (int k = 0; k < n; k++) begin
      sb_t e;
      e.tag = tag;
      e.k   = k;
      e.exp = grant && (k >= lat);
      sb_q.push_back(e);
    end
  endfunction

  // Raise enter with a password; returns just after the sampling edge, enter still high.
  task automatic pulse(input logic [7:0] s);
    @(negedge clk);
    senha_digitada = s;
    enter          = 1'b1;
    @(posedge clk);
  endtask

  // Wait for the scoreboard to empty, with a cycle budget.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: %0d entries left, expected 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'd146, 1'b1, 1};
    vecs[1]  = '{8'd1,   1'b0, 0};
    vecs[2]  = '{8'd199, 1'b1, 2};
    vecs[3]  = '{8'd7,   1'b1, 16};
    vecs[4]  = '{8'd23,  1'b1, 3};
    vecs[5]  = '{8'd250, 1'b1, 15};
    vecs[6]  = '{8'd0,   1'b0, 0};
    vecs[7]  = '{8'd145, 1'b0, 0};
    vecs[8]  = '{8'd240, 1'b1, 14};
    vecs[9]  = '{8'd146, 1'b1, 1};
    vecs[10] = '{8'd88,  1'b1, 5};
    vecs[11] = '{8'd255, 1'b0, 0};

    rst            = 1'b0;
    enter          = 1'b0;
    senha_digitada = 8'd146;

    // Reset held with enter toggling, then released: no search may start.
    @(posedge clk);
    push_seq("reset", 1'b0, 0, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      enter = ~enter;
    end
    @(negedge clk);
    enter = 1'b0;
    rst   = 1'b1;
    drain("reset");

    // Table-driven vectors.
    for (int v = 0; v < 12; v++) begin
      string tag;
      tag = $sformatf("vec%0d_%0d", v, vecs[v].senha);
      pulse(vecs[v].senha);
      push_seq(tag, vecs[v].grant, vecs[v].lat, vecs[v].grant ? vecs[v].lat + 2 : 18);
      @(negedge clk);
      enter = 1'b0;
      drain(tag);
    end

    // enter held high for 10 cycles gives a single search and a held grant.
    pulse(8'd146);
    push_seq("hold", 1'b1, 1, 12);
    repeat (9) @(negedge clk);
    @(negedge clk);
    enter = 1'b0;
    drain("hold");

    // Second enter edge during a miss search is ignored.
    pulse(8'd1);
    push_seq("ignore2nd", 1'b0, 0, 18);
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    @(negedge clk);
    senha_digitada = 8'd146;
    enter          = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    drain("ignore2nd");

    // Reset at E+5 aborts a search that would have granted at E+16.
    pulse(8'd7);
    push_seq("rst_mid", 1'b0, 0, 21);
    @(negedge clk);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drain("rst_mid");

    pulse(8'd146);
    push_seq("after_rst", 1'b1, 1, 3);
    @(negedge clk);
    enter = 1'b0;
    drain("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
